ascon_inv_permutation: RTL and testbench



---
 rtl/ascon_pkg.sv | 60 ++++++
 rtl/ascon_inv_round.sv | 37 +++
 rtl/ascon_inv_permutation.sv | 168 ++++++++++++++++
 tb/tb_ascon_inv_permutation.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared widths, tables and helpers for the inverse ASCON permutation.
//   STATE_W/WORD_W : state and word widths (five 64-bit words, x0 in the top bits)
//   RC             : round constants, indexed by round index 0..11
//   INV_SBOX       : inverse 5-bit S-box, index {x0,x1,x2,x3,x4} with x0 as MSB
//   ROT_R1/ROT_R2  : per-word rotation pairs of the forward linear layer
//   inv_linear()   : inverse of x ^ ror(x,r1) ^ ror(x,r2)
package ascon_pkg;

  localparam int unsigned STATE_W   = 320;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned N_WORDS   = 5;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned N_RC      = 12;
  localparam int unsigned LIN_STEPS = 6;

  typedef enum logic [IDX_W-1:0] {
    R6  = 4'd6,
    R8  = 4'd8,
    R12 = 4'd12
  } rounds_e;

  localparam logic [7:0] RC [N_RC] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  localparam int unsigned ROT_R1 [N_WORDS] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_R2 [N_WORDS] = '{28, 39, 6, 17, 41};

  // Round constant lookup; indices past the table contribute nothing.
  function automatic logic [7:0] rc_of(input logic [IDX_W-1:0] idx);
    return (32'(idx) < N_RC) ? RC[idx] : 8'h00;
  endfunction

  // Rotate right; the doubled word keeps a zero rotation well defined.
  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] w, input int unsigned s);
    return WORD_W'({w, w} >> s);
  endfunction

  // Sigma^-1 = Sigma^63 = prod_k Sigma^(2^k); squaring a rotation polynomial
  // over GF(2) just doubles its rotation amounts, giving six XOR-rotate stages.
  function automatic logic [WORD_W-1:0] inv_linear(input logic [WORD_W-1:0] w,
                                                   input int unsigned r1,
                                                   input int unsigned r2);
    logic [WORD_W-1:0] acc;
    acc = w;
    for (int unsigned k = 0; k < LIN_STEPS; k++) begin
      acc = acc ^ ror(acc, (r1 << k) % WORD_W) ^ ror(acc, (r2 << k) % WORD_W);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ascon_inv_round.sv
// ascon_inv_round: one combinational inverse ASCON round.
//   i_state : 320-bit state entering the inverse round (x0 at [319:256])
//   i_idx   : round-constant index of the forward round being undone
//   o_state : state after inverse linear layer, inverse S-box, constant removal
module ascon_inv_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [STATE_W-1:0] o_state
);

  logic [N_WORDS-1:0][WORD_W-1:0] w_lin;
  logic [N_WORDS-1:0][WORD_W-1:0] w_sub;

  // Undo the per-word diffusion first.
  for (genvar i = 0; i < N_WORDS; i++) begin : g_lin
    assign w_lin[i] = inv_linear(i_state[STATE_W-1-WORD_W*i -: WORD_W], ROT_R1[i], ROT_R2[i]);
  end

  // Inverse S-box on each vertical bit-slice.
  for (genvar b = 0; b < WORD_W; b++) begin : g_slice
    logic [4:0] w_in;
    logic [4:0] w_out;
    assign w_in       = {w_lin[0][b], w_lin[1][b], w_lin[2][b], w_lin[3][b], w_lin[4][b]};
    assign w_out      = INV_SBOX[w_in];
    assign w_sub[0][b] = w_out[4];
    assign w_sub[1][b] = w_out[3];
    assign w_sub[2][b] = w_out[2];
    assign w_sub[3][b] = w_out[1];
    assign w_sub[4][b] = w_out[0];
  end

  // Constant removal touches only the low byte of x2.
  assign o_state = {w_sub[0], w_sub[1], w_sub[2] ^ WORD_W'(rc_of(i_idx)), w_sub[3], w_sub[4]};

endmodule

// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation: iterative inverse ASCON permutation p^-a, a in {6, 8, 12}.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_state/in_rounds sampled at accept
//   in_state, in_rounds : permuted 320-bit state and round count a
//   out_valid/out_ready : output handshake; out_state held until taken
//   out_state           : recovered state
//   busy                : high whenever a job is in flight or waiting to drain
//   out_err             : only with ASCON_INV_ERR_EN; flags an illegal round count
// Parameter UNROLL (1 or 2): inverse rounds applied per clock.
// Macro ASCON_INV_ERR_EN: illegal counts bypass the datapath and raise out_err;
// without it an illegal count runs the full 12 rounds.
module ascon_inv_permutation
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [IDX_W-1:0]   in_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
`ifdef ASCON_INV_ERR_EN
  output logic               out_err,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(N_RC - 1);
  localparam logic [IDX_W-1:0] STEP      = IDX_W'(UNROLL);
  localparam logic [IDX_W-1:0] LAST_OFS  = IDX_W'(UNROLL - 1);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_inv_permutation: UNROLL must be 1 or 2");
  end

  state_e             r_state, w_state_nxt;
  logic [STATE_W-1:0] r_data, w_data_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_stop, w_stop_nxt;
  logic [IDX_W-1:0]   w_stop_dec;
  logic               r_in_ready, r_out_valid, r_busy;
  logic               w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt;
`ifdef ASCON_INV_ERR_EN
  logic               r_err, w_err_nxt;
  logic               w_legal;
`endif

  // Round chain: sub-round u undoes the round with index r_idx - u.
  logic [STATE_W-1:0] w_chain [UNROLL+1];
  assign w_chain[0] = r_data;
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    ascon_inv_round u_round (
      .i_state (w_chain[u]),
      .i_idx   (r_idx - IDX_W'(u)),
      .o_state (w_chain[u+1])
    );
  end

  // Last round index to undo is 12 - a; unknown counts fall back to a = 12.
  always_comb begin
    w_stop_dec = '0;
`ifdef ASCON_INV_ERR_EN
    w_legal = 1'b1;
`endif
    case (in_rounds)
      R6:      w_stop_dec = IDX_W'(N_RC - 6);
      R8:      w_stop_dec = IDX_W'(N_RC - 8);
      R12:     w_stop_dec = '0;
      default: begin
        w_stop_dec = '0;
`ifdef ASCON_INV_ERR_EN
        w_legal = 1'b0;
`endif
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
`ifdef ASCON_INV_ERR_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in_state;
          w_idx_nxt   = IDX_FIRST;
          w_stop_nxt  = w_stop_dec;
          w_state_nxt = S_RUN;
`ifdef ASCON_INV_ERR_EN
          w_err_nxt   = ~w_legal;
`endif
        end
      end
      S_RUN: begin
        w_data_nxt = w_chain[UNROLL];
        w_idx_nxt  = r_idx - STEP;
        if (r_idx - LAST_OFS == r_stop) w_state_nxt = S_DONE;
`ifdef ASCON_INV_ERR_EN
        // Illegal count: one pass-through cycle, state untouched.
        if (r_err) begin
          w_data_nxt  = r_data;
          w_idx_nxt   = r_idx;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
`ifdef ASCON_INV_ERR_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_idx       <= '0;
      r_stop      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ASCON_INV_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_idx       <= w_idx_nxt;
      r_stop      <= w_stop_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
`ifdef ASCON_INV_ERR_EN
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_state = r_data;
`ifdef ASCON_INV_ERR_EN
  assign out_err   = r_err;
`endif

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// tb_ascon_inv_permutation: directed bench for the inverse ASCON permutation.
// Two instances (UNROLL = 1 and 2) share the input side; expected states come
// from a forward ASCON model in this file, round-tripped through the DUTs.
module tb_ascon_inv_permutation;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [319:0] in_state = '0;
  logic [3:0]   in_rounds = 4'd12;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic [319:0] out_state1, out_state2;
`ifdef ASCON_INV_ERR_EN
  logic         out_err1, out_err2;
  logic         exp_err = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [319:0] orig;

  always #5 clk = ~clk;

  ascon_inv_permutation #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid1),
    .out_ready(out_ready), .out_state(out_state1),
`ifdef ASCON_INV_ERR_EN
    .out_err(out_err1),
`endif
    .busy(busy1)
  );

  ascon_inv_permutation #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid2),
    .out_ready(out_ready), .out_state(out_state2),
`ifdef ASCON_INV_ERR_EN
    .out_err(out_err2),
`endif
    .busy(busy2)
  );

  // Forward ASCON S-box.
  localparam logic [4:0] FSBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] w, input int s);
    return (w >> s) | (w << (64 - s));
  endfunction

  // One forward round: constant addition, substitution, linear diffusion.
  function automatic logic [319:0] fwd_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      v = FSBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
      x[0][b] = v[4]; x[1][b] = v[3]; x[2][b] = v[2]; x[3][b] = v[1]; x[4][b] = v[0];
    end
    x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
    x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
    x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
    x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
    x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] fwd_perm(input logic [319:0] s, input int a);
    logic [319:0] t;
    t = s;
    for (int r = 12 - a; r < 12; r++) t = fwd_round(t, r);
    return t;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom();
    return t;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one job on both DUTs, measure latency, check result, then drain.
  task automatic run_job(input int id, input logic [319:0] st, input logic [3:0] rnd,
                         input logic [319:0] exp_st, input int lat1_exp, input int lat2_exp);
    int lat1, lat2;
    lat1 = -1;
    lat2 = -1;
    check($sformatf("j%0d.in_ready1", id), 320'(in_ready1), 320'(1'b1));
    check($sformatf("j%0d.in_ready2", id), 320'(in_ready2), 320'(1'b1));
    in_state  = st;
    in_rounds = rnd;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 < 0) lat1 = n;
      if (out_valid2 && lat2 < 0) lat2 = n;
      if (lat1 >= 0 && lat2 >= 0) break;
    end
    check($sformatf("j%0d.latency1", id), 320'(lat1), 320'(lat1_exp));
    check($sformatf("j%0d.latency2", id), 320'(lat2), 320'(lat2_exp));
    check($sformatf("j%0d.state1", id), out_state1, exp_st);
    check($sformatf("j%0d.state2", id), out_state2, exp_st);
`ifdef ASCON_INV_ERR_EN
    check($sformatf("j%0d.err1", id), 320'(out_err1), 320'(exp_err));
    check($sformatf("j%0d.err2", id), 320'(out_err2), 320'(exp_err));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("j%0d.drain_valid1", id), 320'(out_valid1), 320'(1'b0));
    check($sformatf("j%0d.drain_valid2", id), 320'(out_valid2), 320'(1'b0));
    check($sformatf("j%0d.drain_busy1", id), 320'(busy1), 320'(1'b0));
    check($sformatf("j%0d.drain_ready2", id), 320'(in_ready2), 320'(1'b1));
`ifdef ASCON_INV_ERR_EN
    check($sformatf("j%0d.err_clr1", id), 320'(out_err1), 320'(1'b0));
`endif
  endtask

  initial begin
    // Reset state while rst is held.
    @(posedge clk); @(posedge clk); #1;
    check("rst.in_ready1", 320'(in_ready1), 320'(1'b1));
    check("rst.in_ready2", 320'(in_ready2), 320'(1'b1));
    check("rst.out_valid1", 320'(out_valid1), 320'(1'b0));
    check("rst.out_valid2", 320'(out_valid2), 320'(1'b0));
    check("rst.busy1", 320'(busy1), 320'(1'b0));
    check("rst.busy2", 320'(busy2), 320'(1'b0));
    check("rst.state1", out_state1, 320'h0);
    check("rst.state2", out_state2, 320'h0);
    rst = 1'b0;

    // Zero state through p^12 and back.
    run_job(1, fwd_perm(320'h0, 12), 4'd12, 320'h0, 12, 6);

    // Only bit 0 of every word set.
    orig = {5{64'h1}};
    run_job(2, fwd_perm(orig, 12), 4'd12, orig, 12, 6);
    run_job(3, fwd_perm(orig, 6), 4'd6, orig, 6, 3);

    // Random round trips for every legal round count.
    for (int k = 0; k < 8; k++) begin
      orig = rand_state();
      run_job(10 + 3*k, fwd_perm(orig, 6), 4'd6, orig, 6, 3);
      orig = rand_state();
      run_job(11 + 3*k, fwd_perm(orig, 8), 4'd8, orig, 8, 4);
      orig = rand_state();
      run_job(12 + 3*k, fwd_perm(orig, 12), 4'd12, orig, 12, 6);
    end

    // Illegal round counts.
    orig = rand_state();
`ifdef ASCON_INV_ERR_EN
    exp_err = 1'b1;
    run_job(50, orig, 4'd7, orig, 1, 1);
    run_job(51, orig, 4'd15, orig, 1, 1);
    exp_err = 1'b0;
`else
    run_job(50, fwd_perm(orig, 12), 4'd7, orig, 12, 6);
    run_job(51, fwd_perm(orig, 12), 4'd15, orig, 12, 6);
`endif

    // Backpressure: hold DONE for 20 cycles while a second job is offered.
    orig = rand_state();
    in_state  = fwd_perm(orig, 8);
    in_rounds = 4'd8;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid1 && out_valid2) break;
      @(posedge clk); #1;
    end
    check("bp.valid1", 320'(out_valid1), 320'(1'b1));
    check("bp.valid2", 320'(out_valid2), 320'(1'b1));
    for (int c = 0; c < 20; c++) begin
      in_valid  = 1'b1;
      in_state  = ~orig;
      in_rounds = 4'd6;
      @(posedge clk); #1;
      check($sformatf("bp%0d.state1", c), out_state1, orig);
      check($sformatf("bp%0d.state2", c), out_state2, orig);
      check($sformatf("bp%0d.valid1", c), 320'(out_valid1), 320'(1'b1));
      check($sformatf("bp%0d.ready1", c), 320'(in_ready1), 320'(1'b0));
      check($sformatf("bp%0d.ready2", c), 320'(in_ready2), 320'(1'b0));
    end
    // Handshake with in_valid still high: back to IDLE, no re-accept.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp.rel_ready1", 320'(in_ready1), 320'(1'b1));
    check("bp.rel_ready2", 320'(in_ready2), 320'(1'b1));
    check("bp.rel_busy1", 320'(busy1), 320'(1'b0));
    check("bp.rel_busy2", 320'(busy2), 320'(1'b0));
    check("bp.rel_valid1", 320'(out_valid1), 320'(1'b0));

    // Reset in the middle of a 12-round job.
    orig = rand_state();
    in_state  = fwd_perm(orig, 12);
    in_rounds = 4'd12;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid.ready1", 320'(in_ready1), 320'(1'b0));
    check("mid.busy1", 320'(busy1), 320'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid.rst_valid1", 320'(out_valid1), 320'(1'b0));
    check("mid.rst_ready1", 320'(in_ready1), 320'(1'b1));
    check("mid.rst_ready2", 320'(in_ready2), 320'(1'b1));
    check("mid.rst_busy1", 320'(busy1), 320'(1'b0));
    check("mid.rst_state1", out_state1, 320'h0);
    #2;
    rst = 1'b0;
    orig = rand_state();
    run_job(60, fwd_perm(orig, 12), 4'd12, orig, 12, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
